zeroheti_apb_mgr: RTL and testbench



---
 rtl/zeroheti_apb_mgr_pkg.sv | 13 +
 rtl/zeroheti_apb_mgr_if.sv | 40 ++++
 rtl/zeroheti_apb_mgr.sv | 125 ++++++++++++
 tb/tb_zeroheti_apb_mgr.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zeroheti_apb_mgr_pkg.sv
// Shared types and defaults for the zeroHETI APB manager.
package zeroheti_apb_mgr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mgr_state_e;

    localparam int unsigned ApbMgrTimeoutDflt = 255;

endpackage

// File: rtl/zeroheti_apb_mgr_if.sv
// Request/response port plus APB3 bus of the zeroHETI APB manager.
// master = manager side, slave = requesting agent and APB subordinate side.
interface zeroheti_apb_mgr_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [AddrWidth-1:0] req_addr_i;
    logic                 req_write_i;
    logic [DataWidth-1:0] req_wdata_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [DataWidth-1:0] rsp_rdata_o;
    logic                 rsp_err_o;
    logic                 timeout_o;
    logic [AddrWidth-1:0] paddr_o;
    logic                 pwrite_o;
    logic [DataWidth-1:0] pwdata_o;
    logic                 psel_o;
    logic                 penable_o;
    logic [DataWidth-1:0] prdata_i;
    logic                 pready_i;
    logic                 pslverr_i;

    modport master (
        input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, rsp_ready_i,
        input  prdata_i, pready_i, pslverr_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, timeout_o,
        output paddr_o, pwrite_o, pwdata_o, psel_o, penable_o
    );

    modport slave (
        output req_valid_i, req_addr_i, req_write_i, req_wdata_i, rsp_ready_i,
        output prdata_i, pready_i, pslverr_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, timeout_o,
        input  paddr_o, pwrite_o, pwdata_o, psel_o, penable_o
    );

endinterface

// File: rtl/zeroheti_apb_mgr.sv
// APB3 manager: one valid/ready request becomes one SETUP+ACCESS transfer.
// Optional ACCESS watchdog enabled by defining ZEROHETI_APB_MGR_TIMEOUT_EN.
module zeroheti_apb_mgr
    import zeroheti_apb_mgr_pkg::*;
#(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = ApbMgrTimeoutDflt
) (
    input  logic               clk_i,
    input  logic               rst_i,
    zeroheti_apb_mgr_if.master bus
);

    apb_mgr_state_e       r_state;
    logic                 r_req_ready;
    logic                 r_rsp_valid;
    logic [DataWidth-1:0] r_rsp_rdata;
    logic                 r_rsp_err;
    logic [AddrWidth-1:0] r_paddr;
    logic                 r_pwrite;
    logic [DataWidth-1:0] r_pwdata;
    logic                 r_psel;
    logic                 r_penable;

`ifdef ZEROHETI_APB_MGR_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] r_cnt;
    logic            r_timeout;
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TimeoutCycles == 0);
`endif

    // All outputs are decoded one cycle early so they leave flops directly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
`ifdef ZEROHETI_APB_MGR_TIMEOUT_EN
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
`ifdef ZEROHETI_APB_MGR_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        r_paddr     <= bus.req_addr_i;
                        r_pwrite    <= bus.req_write_i;
                        r_pwdata    <= bus.req_wdata_i;
                        r_req_ready <= 1'b0;
                        r_psel      <= 1'b1;
                        r_state     <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
`ifdef ZEROHETI_APB_MGR_TIMEOUT_EN
                    r_cnt     <= '0;
`endif
                end
                ACCESS: begin
                    // A late pready still wins over the watchdog in the same cycle.
                    if (bus.pready_i) begin
                        r_rsp_rdata <= r_pwrite ? '0 : bus.prdata_i;
                        r_rsp_err   <= bus.pslverr_i;
                        r_rsp_valid <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= RESP;
                    end
`ifdef ZEROHETI_APB_MGR_TIMEOUT_EN
                    else if (r_cnt == CntW'(TimeoutCycles)) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_timeout   <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = r_req_ready;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_rdata_o = r_rsp_rdata;
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.paddr_o     = r_paddr;
    assign bus.pwrite_o    = r_pwrite;
    assign bus.pwdata_o    = r_pwdata;
    assign bus.psel_o      = r_psel;
    assign bus.penable_o   = r_penable;
`ifdef ZEROHETI_APB_MGR_TIMEOUT_EN
    assign bus.timeout_o   = r_timeout;
`else
    assign bus.timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_zeroheti_apb_mgr.sv
// Directed bench for zeroheti_apb_mgr against a behavioural APB subordinate
// with programmable wait states, read data and pslverr.
module tb_zeroheti_apb_mgr;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    zeroheti_apb_mgr_if #(.AddrWidth(32), .DataWidth(32)) bus ();

    zeroheti_apb_mgr #(
        .AddrWidth    (32),
        .DataWidth    (32),
        .TimeoutCycles(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural subordinate: pready after sub_waits ACCESS cycles.
    bit          sub_en;
    int          sub_waits;
    logic [31:0] sub_rdata;
    logic        sub_err;
    int          acc_cnt;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    int          wr_count;

    assign bus.pready_i  = sub_en && bus.psel_o && bus.penable_o && (acc_cnt == sub_waits);
    assign bus.prdata_i  = sub_rdata;
    assign bus.pslverr_i = sub_err;

    always @(posedge clk) begin
        if (bus.psel_o && bus.penable_o && !bus.pready_i) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (bus.psel_o && bus.penable_o && bus.pready_i && bus.pwrite_o) begin
            wr_addr  <= bus.paddr_o;
            wr_data  <= bus.pwdata_o;
            wr_count <= wr_count + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1);
    end

    // Called at a negedge in IDLE; returns at the negedge of cycle 1.
    task automatic start_req(input logic [31:0] a, input logic w, input logic [31:0] d);
        bus.req_addr_i  = a;
        bus.req_write_i = w;
        bus.req_wdata_i = d;
        bus.req_valid_i = 1'b1;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    // From cycle 1, advance until rsp_valid or max_cyc; reports cycle and observations.
    task automatic wait_rsp(input int max_cyc, output int cyc, output int addr_moves,
                            output int to_pulses);
        logic [31:0] a0;
        a0 = bus.paddr_o;
        cyc = 1;
        addr_moves = 0;
        to_pulses = 0;
        while (bus.rsp_valid_o !== 1'b1 && cyc < max_cyc) begin
            if (bus.psel_o && bus.paddr_o !== a0) addr_moves++;
            @(negedge clk);
            cyc++;
            if (bus.timeout_o === 1'b1) to_pulses++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.req_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_req_ready: got %b required 1", bus.req_ready_o);
        end
        checks++;
        if ({bus.rsp_valid_o, bus.rsp_err_o, bus.timeout_o, bus.psel_o, bus.penable_o, bus.pwrite_o} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b required 000000",
                {bus.rsp_valid_o, bus.rsp_err_o, bus.timeout_o, bus.psel_o, bus.penable_o, bus.pwrite_o});
        end
        checks++;
        if ({bus.paddr_o, bus.pwdata_o, bus.rsp_rdata_o} !== 96'h0) begin
            errors++; $display("FAIL reset_data: paddr %h pwdata %h rdata %h required 0",
                bus.paddr_o, bus.pwdata_o, bus.rsp_rdata_o);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: done");
    endtask

    task automatic test_write_zero_wait();
        sub_en = 1; sub_waits = 0; sub_err = 0; sub_rdata = 32'hFFFF_FFFF;
        bus.rsp_ready_i = 1'b1;
        checks++;
        if (bus.req_ready_o !== 1'b1) begin
            errors++; $display("FAIL wr_c0_req_ready: got %b required 1", bus.req_ready_o);
        end
        start_req(32'h0003_0000, 1'b1, 32'h1234_5678);
        checks++;
        if ({bus.psel_o, bus.penable_o} !== 2'b10) begin
            errors++; $display("FAIL wr_c1_setup: psel/penable %b required 10", {bus.psel_o, bus.penable_o});
        end
        checks++;
        if (bus.paddr_o !== 32'h0003_0000 || bus.pwdata_o !== 32'h1234_5678 || bus.pwrite_o !== 1'b1) begin
            errors++; $display("FAIL wr_c1_bus: paddr %h pwdata %h pwrite %b required 00030000 12345678 1",
                bus.paddr_o, bus.pwdata_o, bus.pwrite_o);
        end
        @(negedge clk);
        checks++;
        if ({bus.psel_o, bus.penable_o} !== 2'b11) begin
            errors++; $display("FAIL wr_c2_access: psel/penable %b required 11", {bus.psel_o, bus.penable_o});
        end
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid_o, bus.rsp_err_o, bus.psel_o, bus.penable_o, bus.req_ready_o} !== 5'b10000
            || bus.rsp_rdata_o !== 32'h0) begin
            errors++; $display("FAIL wr_c3_rsp: valid/err/psel/pen/rdy %b rdata %h required 10000 00000000",
                {bus.rsp_valid_o, bus.rsp_err_o, bus.psel_o, bus.penable_o, bus.req_ready_o}, bus.rsp_rdata_o);
        end
        @(negedge clk);
        checks++;
        if ({bus.req_ready_o, bus.rsp_valid_o} !== 2'b10) begin
            errors++; $display("FAIL wr_c4_idle: req_ready/rsp_valid %b required 10", {bus.req_ready_o, bus.rsp_valid_o});
        end
        checks++;
        if (wr_addr !== 32'h0003_0000 || wr_data !== 32'h1234_5678) begin
            errors++; $display("FAIL wr_landed: addr %h data %h required 00030000 12345678", wr_addr, wr_data);
        end
        $display("write zero-wait: addr 00030000 data 12345678");
    endtask

    task automatic test_read_wait();
        int cyc, moves, to;
        sub_en = 1; sub_waits = 5; sub_err = 0; sub_rdata = 32'hCAFE_F00D;
        bus.rsp_ready_i = 1'b1;
        start_req(32'h0003_0008, 1'b0, 32'h0);
        wait_rsp(20, cyc, moves, to);
        checks++;
        if (cyc !== 8) begin
            errors++; $display("FAIL rd_wait_latency: rsp at cycle %0d required 8", cyc);
        end
        checks++;
        if (bus.rsp_rdata_o !== 32'hCAFE_F00D || bus.rsp_err_o !== 1'b0) begin
            errors++; $display("FAIL rd_wait_data: rdata %h err %b required cafef00d 0", bus.rsp_rdata_o, bus.rsp_err_o);
        end
        checks++;
        if (moves !== 0) begin
            errors++; $display("FAIL rd_wait_paddr_stable: %0d changes required 0", moves);
        end
        @(negedge clk);
        $display("read 5 wait states: rdata %h at cycle %0d", bus.rsp_rdata_o, cyc);
    endtask

    task automatic test_slverr();
        int cyc, moves, to;
        sub_en = 1; sub_waits = 2; sub_err = 1; sub_rdata = 32'hBAD0_0001;
        bus.rsp_ready_i = 1'b1;
        start_req(32'h0003_0004, 1'b0, 32'h0);
        wait_rsp(20, cyc, moves, to);
        checks++;
        if (cyc !== 5 || bus.rsp_err_o !== 1'b1 || bus.rsp_rdata_o !== 32'hBAD0_0001) begin
            errors++; $display("FAIL slverr_rsp: cycle %0d err %b rdata %h required 5 1 bad00001",
                cyc, bus.rsp_err_o, bus.rsp_rdata_o);
        end
        @(negedge clk);
        sub_err = 0;
        $display("read with pslverr: err 1 rdata bad00001");
    endtask

    task automatic test_backpressure();
        int cyc, moves, to;
        sub_en = 1; sub_waits = 0; sub_err = 0; sub_rdata = 32'h1122_3344;
        bus.rsp_ready_i = 1'b0;
        start_req(32'h0003_0010, 1'b0, 32'h0);
        wait_rsp(10, cyc, moves, to);
        checks++;
        if (cyc !== 3) begin
            errors++; $display("FAIL bp_latency: rsp at cycle %0d required 3", cyc);
        end
        // A pending second request must be ignored while the response is held.
        bus.req_addr_i  = 32'h0003_0020;
        bus.req_write_i = 1'b1;
        bus.req_wdata_i = 32'h55AA_55AA;
        bus.req_valid_i = 1'b1;
        sub_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== 32'h1122_3344 || bus.req_ready_o !== 1'b0
                || bus.psel_o !== 1'b0) begin
                errors++; $display("FAIL bp_hold_%0d: valid %b rdata %h req_ready %b psel %b required 1 11223344 0 0",
                    i, bus.rsp_valid_o, bus.rsp_rdata_o, bus.req_ready_o, bus.psel_o);
            end
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.req_ready_o, bus.rsp_valid_o} !== 2'b10) begin
            errors++; $display("FAIL bp_release: req_ready/rsp_valid %b required 10", {bus.req_ready_o, bus.rsp_valid_o});
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        checks++;
        if ({bus.psel_o, bus.penable_o} !== 2'b10 || bus.paddr_o !== 32'h0003_0020 || bus.pwrite_o !== 1'b1) begin
            errors++; $display("FAIL bp_next_setup: psel/pen %b paddr %h pwrite %b required 10 00030020 1",
                {bus.psel_o, bus.penable_o}, bus.paddr_o, bus.pwrite_o);
        end
        wait_rsp(10, cyc, moves, to);
        @(negedge clk);
        checks++;
        if (wr_addr !== 32'h0003_0020 || wr_data !== 32'h55AA_55AA) begin
            errors++; $display("FAIL bp_next_write: addr %h data %h required 00030020 55aa55aa", wr_addr, wr_data);
        end
        $display("backpressure: held 4 cycles, next request accepted after handshake");
    endtask

    task automatic test_back_to_back();
        logic [8:0] pat;
        int         wc0;
        sub_en = 1; sub_waits = 0; sub_err = 0;
        bus.rsp_ready_i = 1'b1;
        wc0 = wr_count;
        bus.req_addr_i  = 32'h0003_0030;
        bus.req_write_i = 1'b1;
        bus.req_wdata_i = 32'hA5A5_0001;
        bus.req_valid_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            pat[i] = bus.req_ready_o;
            if (i < 8) @(negedge clk);
        end
        bus.req_valid_i = 1'b0;
        checks++;
        if (pat !== 9'b1_0001_0001) begin
            errors++; $display("FAIL b2b_ready_pattern: got %b required 100010001", pat);
        end
        checks++;
        if (wr_count - wc0 !== 2) begin
            errors++; $display("FAIL b2b_transfers: got %0d required 2", wr_count - wc0);
        end
        @(negedge clk);
        $display("back-to-back: handshakes every 4 cycles");
    endtask

`ifdef ZEROHETI_APB_MGR_TIMEOUT_EN
    task automatic test_timeout();
        int cyc, moves, to;
        sub_en = 0; sub_waits = 0; sub_err = 0; sub_rdata = 32'hDEAD_BEEF;
        bus.rsp_ready_i = 1'b1;
        start_req(32'h0003_0040, 1'b0, 32'h0);
        wait_rsp(20, cyc, moves, to);
        checks++;
        if (cyc !== 11 || bus.rsp_err_o !== 1'b1 || bus.rsp_rdata_o !== 32'h0 || bus.psel_o !== 1'b0) begin
            errors++; $display("FAIL to_rsp: cycle %0d err %b rdata %h psel %b required 11 1 00000000 0",
                cyc, bus.rsp_err_o, bus.rsp_rdata_o, bus.psel_o);
        end
        @(negedge clk);
        checks++;
        if (to !== 1 || bus.timeout_o !== 1'b0) begin
            errors++; $display("FAIL to_pulse: pulses %0d timeout_o after %b required 1 0", to, bus.timeout_o);
        end
        sub_en = 1; sub_waits = 8; sub_rdata = 32'h600D_F00D;
        start_req(32'h0003_0044, 1'b0, 32'h0);
        wait_rsp(20, cyc, moves, to);
        checks++;
        if (cyc !== 11 || bus.rsp_err_o !== 1'b0 || bus.rsp_rdata_o !== 32'h600D_F00D || to !== 0) begin
            errors++; $display("FAIL to_late_ready: cycle %0d err %b rdata %h pulses %0d required 11 0 600df00d 0",
                cyc, bus.rsp_err_o, bus.rsp_rdata_o, to);
        end
        @(negedge clk);
        $display("watchdog: timeout at cycle 11, late pready completes normally");
    endtask
`else
    task automatic test_no_timeout();
        int acc, to;
        sub_en = 0; sub_waits = 0; sub_err = 0;
        bus.rsp_ready_i = 1'b1;
        acc = 0; to = 0;
        start_req(32'h0003_0040, 1'b0, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (bus.psel_o && bus.penable_o && !bus.rsp_valid_o) acc++;
            if (bus.timeout_o !== 1'b0) to++;
            @(negedge clk);
        end
        checks++;
        if (acc !== 40 || to !== 0) begin
            errors++; $display("FAIL no_to_wait: access cycles %0d timeout cycles %0d required 40 0", acc, to);
        end
        $display("no watchdog: ACCESS held 40 cycles");
    endtask
`endif

    task automatic test_reset_mid();
        int late;
        sub_en = 0;
        bus.rsp_ready_i = 1'b1;
        if (bus.req_ready_o === 1'b1) begin
            start_req(32'h0003_0050, 1'b0, 32'h0);
            repeat (2) @(negedge clk);
        end
        checks++;
        if ({bus.psel_o, bus.penable_o} !== 2'b11) begin
            errors++; $display("FAIL rst_mid_in_access: psel/pen %b required 11", {bus.psel_o, bus.penable_o});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sub_en = 1; sub_waits = 0;
        checks++;
        if ({bus.psel_o, bus.penable_o, bus.rsp_valid_o, bus.req_ready_o} !== 4'b0001) begin
            errors++; $display("FAIL rst_mid_outputs: psel/pen/rsp_valid/req_ready %b required 0001",
                {bus.psel_o, bus.penable_o, bus.rsp_valid_o, bus.req_ready_o});
        end
        late = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o !== 1'b0 || bus.psel_o !== 1'b0) late++;
        end
        checks++;
        if (late !== 0) begin
            errors++; $display("FAIL rst_mid_discard: %0d cycles with activity required 0", late);
        end
        $display("reset during ACCESS: bus released, response discarded");
    endtask

    initial begin
        rst             = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_write_i = 1'b0;
        bus.req_wdata_i = '0;
        bus.rsp_ready_i = 1'b0;
        sub_en = 0; sub_waits = 0; sub_err = 0; sub_rdata = '0;
        acc_cnt = 0; wr_addr = '0; wr_data = '0; wr_count = 0;

        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slverr();
        test_backpressure();
        test_back_to_back();
`ifdef ZEROHETI_APB_MGR_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
